// File: rtl/jpeg_pkg.sv
// Shared constants and types for the JPEG stripe datapath.
// Geometry: 8x8 MCUs, 16 blocks per stripe (128 pixels wide, 8 rows tall).
package jpeg_pkg;

    localparam int unsigned PIX_W          = 8;
    localparam int unsigned MCU_W          = 8;
    localparam int unsigned BLK_PER_STRIPE = 16;
    localparam int unsigned STRIPE_W       = BLK_PER_STRIPE * MCU_W;
    localparam int unsigned RAM_AW         = $clog2(STRIPE_W);
    localparam int unsigned NUM_BANKS      = 2;
    localparam int unsigned STRIPE_PIX     = STRIPE_W * MCU_W;
    localparam int unsigned WR_CW          = $clog2(STRIPE_W);
    localparam int unsigned RD_CW          = $clog2(STRIPE_PIX);
    localparam int unsigned ROW_W          = $clog2(MCU_W);

    typedef logic [PIX_W-1:0] pix_t;

    // Tag travelling alongside a RAM read so the output mux picks the right lane/bank.
    typedef struct packed {
        logic             vld;
        logic             bank;
        logic [ROW_W-1:0] lane;
    } rd_tag_t;

endpackage

// File: rtl/mcu_raster_if.sv
// Column-in / pixel-out stream bundle for mcu_raster.
//   din[r]      : block row r of one 8x8 column
//   din_valid   : din carries a column
//   din_ready   : sink can accept a column this cycle
//   dout        : raster pixel
//   dout_valid  : dout carries a pixel (no backpressure)
interface mcu_raster_if;
    import jpeg_pkg::*;

    pix_t din [MCU_W-1:0];
    logic din_valid;
    logic din_ready;
    pix_t dout;
    logic dout_valid;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output dout,
        output dout_valid
    );

endinterface

// File: rtl/ram_8bx128.sv
// Single-port 8b x 128 RAM, write-enable, registered read (1-clk latency).
//   clk  : clock
//   we   : write din to addr
//   addr : word address
//   din  : write data
//   dout : read data for the address presented on the previous cycle
module ram_8bx128
    import jpeg_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [RAM_AW-1:0] addr,
    input  pix_t              din,
    output pix_t              dout
);

    pix_t mem [2**RAM_AW];

    // Storage write and synchronous read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mcu_raster.sv
// MCU-column to raster converter for one 8-row x 128-pixel stripe.
// Columns of 8x8 blocks are written into one of two ping-pong banks while the
// other bank is read out row by row, one pixel per cycle.
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : slave side of mcu_raster_if (din/din_valid/din_ready in,
//           dout/dout_valid out)
module mcu_raster
    import jpeg_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    mcu_raster_if.slave  bus
);

    logic [WR_CW-1:0]     wr_cnt;
    logic                 wr_sel;
    logic [RD_CW-1:0]     rd_cnt;
    logic                 rd_sel;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_nxt_c;

    logic                 accept_c;
    logic                 rd_issue_c;
    logic                 wr_last_c;
    logic                 rd_last_c;
    logic [ROW_W-1:0]     rd_row_c;
    logic [RAM_AW-1:0]    rd_px_c;

    logic [NUM_BANKS-1:0] ram_we_c;
    logic [RAM_AW-1:0]    ram_addr_c [NUM_BANKS];
    pix_t                 ram_q      [NUM_BANKS][MCU_W];

    rd_tag_t              tag_q;
    rd_tag_t              tag_nxt_c;
    pix_t                 rd_mux_c;
    pix_t                 dout_q;
    logic                 dout_valid_q;

    // A bank can take columns only while it is not waiting to drain.
    assign bus.din_ready  = ~full[wr_sel];
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

    // Handshake, counter decode and flag update.
    always_comb begin
        accept_c   = bus.din_valid & ~full[wr_sel];
        rd_issue_c = full[rd_sel];
        wr_last_c  = (wr_cnt == WR_CW'(STRIPE_W - 1));
        rd_last_c  = (rd_cnt == RD_CW'(STRIPE_PIX - 1));
        rd_row_c   = rd_cnt[RD_CW-1 -: ROW_W];
        rd_px_c    = rd_cnt[RAM_AW-1:0];

        // Set and clear always target different banks: the write bank is
        // never full while accepting, the read bank always is while issuing.
        full_nxt_c = full;
        if (accept_c && wr_last_c) begin
            full_nxt_c[wr_sel] = 1'b1;
        end
        if (rd_issue_c && rd_last_c) begin
            full_nxt_c[rd_sel] = 1'b0;
        end
    end

    // Per-bank port steering: the draining bank sees the read address,
    // any other bank sees the write address.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            ram_we_c[b]   = accept_c & (wr_sel == 1'(b));
            ram_addr_c[b] = (rd_issue_c && (rd_sel == 1'(b))) ? rd_px_c : wr_cnt;
        end
    end

    // Bank b, lane l stores stripe row l.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar l = 0; l < MCU_W; l++) begin : g_lane
            ram_8bx128 u_ram (
                .clk  (clk),
                .we   (ram_we_c[b]),
                .addr (ram_addr_c[b]),
                .din  (bus.din[l]),
                .dout (ram_q[b][l])
            );
        end
    end

    // Write/read counters, bank selects and full flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_cnt <= '0;
            wr_sel <= 1'b0;
            rd_cnt <= '0;
            rd_sel <= 1'b0;
            full   <= '0;
        end else begin
            if (accept_c) begin
                wr_cnt <= wr_cnt + WR_CW'(1);
                if (wr_last_c) begin
                    wr_sel <= ~wr_sel;
                end
            end
            if (rd_issue_c) begin
                rd_cnt <= rd_cnt + RD_CW'(1);
                if (rd_last_c) begin
                    rd_sel <= ~rd_sel;
                end
            end
            full <= full_nxt_c;
        end
    end

    // Read tag for the cycle the RAM output becomes valid.
    always_comb begin
        tag_nxt_c      = '0;
        tag_nxt_c.vld  = rd_issue_c;
        tag_nxt_c.bank = rd_sel;
        tag_nxt_c.lane = rd_row_c;
    end

    always_comb begin
        rd_mux_c = ram_q[tag_q.bank][tag_q.lane];
    end

    // RAM-latency tag stage and output register; dout holds when idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tag_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            tag_q        <= tag_nxt_c;
            dout_valid_q <= tag_q.vld;
            if (tag_q.vld) begin
                dout_q <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_mcu_raster.sv
// Self-checking bench for mcu_raster: random/ramp stripes fed as MCU columns,
// output compared against a raster-order reference built from the pixel arrays.
module tb_mcu_raster;
    import jpeg_pkg::*;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    mcu_raster_if bus ();

    mcu_raster dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] pix [4][8][128];
    logic [7:0] got_q [$];
    int         got_cyc [$];
    logic [7:0] exp_q [$];

    int hold_viol = 0;
    logic [7:0] prev_dout = 8'h00;
    logic prev_ok = 1'b0;

    int stall_cycles = 0;
    int ready_rise_cyc = -1;
    int last_acc_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Output capture and hold-while-idle monitoring.
    always @(negedge clk) begin
        if (nrst && bus.dout_valid) begin
            got_q.push_back(bus.dout);
            got_cyc.push_back(cyc);
        end
        if (nrst && prev_ok && !bus.dout_valid && (bus.dout !== prev_dout))
            hold_viol++;
        prev_dout = bus.dout;
        prev_ok = nrst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        return (i < got_cyc.size()) ? got_cyc[i] : -1;
    endfunction

    function automatic int first_bad(input int gb, input int eb, input int n);
        for (int i = 0; i < n; i++)
            if ((gb + i >= got_q.size()) || (got_q[gb+i] !== exp_q[eb+i])) return i;
        return -1;
    endfunction

    function automatic int first_gap(input int gb, input int n);
        for (int i = 1; i < n; i++)
            if ((gb + i >= got_cyc.size()) || (got_cyc[gb+i] != got_cyc[gb] + i)) return i;
        return -1;
    endfunction

    task automatic make_ramp(input int s);
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < 128; x++) pix[s][r][x] = 8'((8 * r + x) % 256);
    endtask

    task automatic make_rand(input int s);
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < 128; x++) pix[s][r][x] = 8'($urandom_range(254));
    endtask

    // Reference: a stripe leaves in raster order, row 0 first.
    task automatic push_exp(input int s);
        for (int r = 0; r < 8; r++)
            for (int x = 0; x < 128; x++) exp_q.push_back(pix[s][r][x]);
    endtask

    // Feed one stripe as 128 columns (x = 8*block + column). Stall cycles
    // present 8'hFF with din_valid high. last_at >= 0 holds back the final column
    // until that cycle.
    task automatic send_stripe(input int s, input int prob, input int last_at);
        int x = 0;
        int n = 0;
        bit v;
        bit in_stall = 0;
        while (x < 128) begin
            if (x == 127 && last_at >= 0 && cyc < last_at) begin
                bus.din_valid = 1'b0;
                for (int r = 0; r < 8; r++) bus.din[r] = 8'hFF;
            end else if (!bus.din_ready) begin
                stall_cycles++;
                in_stall = 1;
                bus.din_valid = 1'b1;
                for (int r = 0; r < 8; r++) bus.din[r] = 8'hFF;
            end else begin
                if (in_stall) begin
                    ready_rise_cyc = cyc;
                    in_stall = 0;
                end
                v = ($urandom_range(99) < prob);
                bus.din_valid = v;
                for (int r = 0; r < 8; r++) bus.din[r] = v ? pix[s][r][x] : 8'hFF;
                if (v) begin
                    last_acc_cyc = cyc;
                    x++;
                end
            end
            @(posedge clk); #1;
            n++;
            if (n > 20000) begin
                $display("FAIL send_stripe stuck: columns=%0d of 128", x);
                $fatal(1, "send_stripe");
            end
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic wait_outputs(input int target, input int budget, output bit to);
        int n = 0;
        to = 0;
        while (got_q.size() < target) begin
            if (n >= budget) begin
                to = 1;
                break;
            end
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        #13;
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dout_valid got=%b exp=0", bus.dout_valid);
        end
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++; $display("FAIL reset_dout got=%h exp=00", bus.dout);
        end
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.din_ready !== 1'b1) begin
            errors++; $display("FAIL reset_din_ready got=%b exp=1", bus.din_ready);
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_dout_valid got=%b exp=0", bus.dout_valid);
        end
    endtask

    task automatic test_single_stripe();
        int base = got_q.size();
        int ebase = exp_q.size();
        int st0 = stall_cycles;
        int bad;
        bit to;
        make_ramp(0);
        push_exp(0);
        send_stripe(0, 100, -1);
        checks++;
        if (stall_cycles != st0) begin
            errors++; $display("FAIL single_ready_low cycles=%0d exp=0", stall_cycles - st0);
        end
        wait_outputs(base + 1024, 2000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL single_timeout got=%0d exp=1024", got_q.size() - base);
        end
        checks++;
        if (cyc_at(base) != last_acc_cyc + 3) begin
            errors++; $display("FAIL single_latency got=%0d exp=%0d", cyc_at(base) - last_acc_cyc, 3);
        end
        bad = first_bad(base, ebase, 1024);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL single_data idx=%0d got=%h exp=%h", bad, got_at(base + bad), exp_q[ebase + bad]);
        end
        bad = first_gap(base, 1024);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL single_gap idx=%0d", bad);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != base + 1024) begin
            errors++; $display("FAIL single_count got=%0d exp=1024", got_q.size() - base);
        end
    endtask

    task automatic test_throttle();
        int base = got_q.size();
        int ebase = exp_q.size();
        int st0 = stall_cycles;
        int bad;
        int ffs = 0;
        bit to;
        ready_rise_cyc = -1;
        for (int s = 1; s <= 3; s++) begin
            make_rand(s);
            push_exp(s);
        end
        for (int s = 1; s <= 3; s++) send_stripe(s, 100, -1);
        wait_outputs(base + 3072, 5000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL throttle_timeout got=%0d exp=3072", got_q.size() - base);
        end
        checks++;
        if (stall_cycles == st0) begin
            errors++; $display("FAIL throttle_no_stall got=0 exp=>0");
        end
        checks++;
        if (ready_rise_cyc != cyc_at(base + 1023) - 1) begin
            errors++; $display("FAIL throttle_ready_rise got=%0d exp=%0d", ready_rise_cyc, cyc_at(base + 1023) - 1);
        end
        bad = first_bad(base, ebase, 3072);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL throttle_data idx=%0d got=%h exp=%h", bad, got_at(base + bad), exp_q[ebase + bad]);
        end
        bad = first_gap(base, 3072);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL throttle_gap idx=%0d", bad);
        end
        for (int i = base; i < got_q.size(); i++)
            if (got_q[i] === 8'hFF) ffs++;
        checks++;
        if (ffs != 0) begin
            errors++; $display("FAIL throttle_stall_data got=%0d exp=0 FF pixels", ffs);
        end
    endtask

    task automatic test_bubbles();
        int base = got_q.size();
        int ebase = exp_q.size();
        int bad;
        bit to;
        for (int s = 1; s <= 3; s++) push_exp(s);
        for (int s = 1; s <= 3; s++) send_stripe(s, 30, -1);
        wait_outputs(base + 3072, 10000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL bubbles_timeout got=%0d exp=3072", got_q.size() - base);
        end
        bad = first_bad(base, ebase, 3072);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL bubbles_data idx=%0d got=%h exp=%h", bad, got_at(base + bad), exp_q[ebase + bad]);
        end
        for (int s = 0; s < 3; s++) begin
            bad = first_gap(base + 1024 * s, 1024);
            checks++;
            if (bad != -1) begin
                errors++; $display("FAIL bubbles_gap stripe=%0d idx=%0d", s, bad);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != base + 3072) begin
            errors++; $display("FAIL bubbles_count got=%0d exp=3072", got_q.size() - base);
        end
    endtask

    // Last column of stripe 2 lands in the cycle stripe 1 issues its final read.
    task automatic test_boundary();
        int base = got_q.size();
        int ebase = exp_q.size();
        int a1;
        int bad;
        bit to;
        make_ramp(0);
        make_rand(1);
        push_exp(0);
        push_exp(1);
        send_stripe(0, 100, -1);
        a1 = last_acc_cyc;
        send_stripe(1, 100, a1 + 1024);
        checks++;
        if (last_acc_cyc != a1 + 1024) begin
            errors++; $display("FAIL boundary_accept_cycle got=%0d exp=%0d", last_acc_cyc - a1, 1024);
        end
        wait_outputs(base + 2048, 4000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL boundary_timeout got=%0d exp=2048", got_q.size() - base);
        end
        bad = first_bad(base, ebase, 2048);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL boundary_data idx=%0d got=%h exp=%h", bad, got_at(base + bad), exp_q[ebase + bad]);
        end
        bad = first_gap(base, 2048);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL boundary_gap idx=%0d", bad);
        end
        checks++;
        if (cyc_at(base + 1024) != last_acc_cyc + 3) begin
            errors++; $display("FAIL boundary_latency got=%0d exp=3", cyc_at(base + 1024) - last_acc_cyc);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (bus.din_ready !== 1'b1 || got_q.size() != base + 2048) begin
            errors++; $display("FAIL boundary_idle ready=%b count=%0d exp ready=1 count=2048", bus.din_ready, got_q.size() - base);
        end
    endtask

    task automatic test_reset_mid_drain();
        int base = got_q.size();
        int base2;
        int ebase2;
        int bad;
        bit to;
        make_rand(2);
        push_exp(2);
        send_stripe(2, 100, -1);
        wait_outputs(base + 500, 2000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL middrain_timeout got=%0d exp=500", got_q.size() - base);
        end
        nrst = 1'b0;
        #1;
        checks++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 8'h00) begin
            errors++; $display("FAIL middrain_reset got valid=%b dout=%h exp valid=0 dout=00", bus.dout_valid, bus.dout);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); nrst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.din_ready !== 1'b1) begin
            errors++; $display("FAIL middrain_ready got=%b exp=1", bus.din_ready);
        end
        base2 = got_q.size();
        ebase2 = exp_q.size();
        make_rand(3);
        push_exp(3);
        send_stripe(3, 100, -1);
        wait_outputs(base2 + 1024, 2000, to);
        checks++;
        if (to) begin
            errors++; $display("FAIL middrain_new_timeout got=%0d exp=1024", got_q.size() - base2);
        end
        checks++;
        if (cyc_at(base2) != last_acc_cyc + 3) begin
            errors++; $display("FAIL middrain_latency got=%0d exp=3", cyc_at(base2) - last_acc_cyc);
        end
        bad = first_bad(base2, ebase2, 1024);
        checks++;
        if (bad != -1) begin
            errors++; $display("FAIL middrain_data idx=%0d got=%h exp=%h", bad, got_at(base2 + bad), exp_q[ebase2 + bad]);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != base2 + 1024) begin
            errors++; $display("FAIL middrain_count got=%0d exp=1024", got_q.size() - base2);
        end
    endtask

    task automatic test_hold();
        checks++;
        if (hold_viol != 0) begin
            errors++; $display("FAIL dout_hold changes=%0d exp=0", hold_viol);
        end
    endtask

    initial begin
        bus.din_valid = 1'b0;
        for (int r = 0; r < 8; r++) bus.din[r] = 8'h00;
        test_reset();
        test_single_stripe();
        test_throttle();
        test_bubbles();
        test_boundary();
        test_reset_mid_drain();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
